// File: rtl/fpu8_pkg.sv
// Shared definitions for the 8-bit FPU: field widths, opcodes,
// special encodings, flag bit positions and the operand class record.
package fpu8_pkg;

  // Format: 1 sign, EXP_W exponent, MAN_W mantissa, bias 7.
  localparam int unsigned EXP_W  = 4;
  localparam int unsigned MAN_W  = 3;
  localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
  localparam int unsigned FLAG_W = 4;

  // Opcodes.
  localparam logic [1:0] _ADDITION       = 2'b00;
  localparam logic [1:0] _SUBTRACTION    = 2'b01;
  localparam logic [1:0] _MULTIPLICATION = 2'b10;
  localparam logic [1:0] _DIVISION       = 2'b11;

  // Special encodings; NaN is always emitted with a positive sign.
  localparam logic [WORD_W-1:0] _PLUS_INF  = 8'h78;
  localparam logic [WORD_W-1:0] _MINUS_INF = 8'hF8;
  localparam logic [WORD_W-1:0] _QNAN      = 8'h7C;
  localparam logic [WORD_W-1:0] _POS_ZERO  = 8'h00;
  localparam logic [WORD_W-1:0] _NEG_ZERO  = 8'h80;

  // Bit positions within flags = {nan_operand, invalid, div_by_zero, inf_operand}.
  localparam int unsigned FLAG_NAN      = 3;
  localparam int unsigned FLAG_INVALID  = 2;
  localparam int unsigned FLAG_DIV_ZERO = 1;
  localparam int unsigned FLAG_INF      = 0;

  // Classification of a single operand.
  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
    logic sign;
  } operand_class_t;

  // Signed infinity.
  function automatic logic [WORD_W-1:0] signed_inf(input logic sign);
    return sign ? _MINUS_INF : _PLUS_INF;
  endfunction

  // Signed zero.
  function automatic logic [WORD_W-1:0] signed_zero(input logic sign);
    return sign ? _NEG_ZERO : _POS_ZERO;
  endfunction

endpackage

// File: rtl/fpu8_classify.sv
// Combinational classifier for one 8-bit FPU operand.
// Ports:
//   operand  in  8  value to classify
//   is_nan   out 1  exponent all ones, mantissa nonzero
//   is_inf   out 1  exponent all ones, mantissa zero
//   is_zero  out 1  exponent and mantissa zero (subnormals are nonzero)
//   sign     out 1  sign bit
module fpu8_classify
  import fpu8_pkg::*;
(
  input  logic [WORD_W-1:0] operand,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero,
  output logic              sign
);

  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] man_field;

  assign exp_field = operand[WORD_W-2 -: EXP_W];
  assign man_field = operand[MAN_W-1:0];

  assign sign    = operand[WORD_W-1];
  assign is_nan  = (&exp_field) & (|man_field);
  assign is_inf  = (&exp_field) & ~(|man_field);
  assign is_zero = ~(|exp_field) & ~(|man_field);

endmodule

// File: rtl/fpu8_exception_unit.sv
// Special-case / exception detector for the 8-bit FPU. Classifies both
// operands, applies the exception rules in priority order and registers
// the flags plus the special result the output mux should select.
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   op               2'b00 add, 2'b01 sub, 2'b10 mul, 2'b11 div
//   in0, in1         operand A and operand B
//   in_valid         inputs valid this cycle
//   exception        OR of flags
//   flags            {nan_operand, invalid, div_by_zero, inf_operand}
//   special_result   replacement result when exception=1, else 8'h00
//   out_valid        in_valid delayed one cycle
module fpu8_exception_unit
  import fpu8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] in0,
  input  logic [WORD_W-1:0] in1,
  input  logic              in_valid,
  output logic              exception,
  output logic [FLAG_W-1:0] flags,
  output logic [WORD_W-1:0] special_result,
  output logic              out_valid
);

  operand_class_t a_cls;
  operand_class_t b_cls;

  logic              any_nan_c;
  logic              any_inf_c;
  logic              invalid_c;
  logic              div_zero_c;
  logic              prod_sign_c;
  logic [FLAG_W-1:0] flags_c;
  logic [WORD_W-1:0] result_c;

  // Operand classification.
  fpu8_classify u_cls_a (
    .operand (in0),
    .is_nan  (a_cls.is_nan),
    .is_inf  (a_cls.is_inf),
    .is_zero (a_cls.is_zero),
    .sign    (a_cls.sign)
  );

  fpu8_classify u_cls_b (
    .operand (in1),
    .is_nan  (b_cls.is_nan),
    .is_inf  (b_cls.is_inf),
    .is_zero (b_cls.is_zero),
    .sign    (b_cls.sign)
  );

  assign any_nan_c   = a_cls.is_nan | b_cls.is_nan;
  assign any_inf_c   = a_cls.is_inf | b_cls.is_inf;
  assign prod_sign_c = a_cls.sign ^ b_cls.sign;

  // Invalid operand combinations per opcode.
  always_comb begin
    invalid_c = 1'b0;
    case (op)
      _ADDITION:       invalid_c = a_cls.is_inf & b_cls.is_inf & (a_cls.sign != b_cls.sign);
      _SUBTRACTION:    invalid_c = a_cls.is_inf & b_cls.is_inf & (a_cls.sign == b_cls.sign);
      _MULTIPLICATION: invalid_c = (a_cls.is_inf & b_cls.is_zero) | (a_cls.is_zero & b_cls.is_inf);
      _DIVISION:       invalid_c = (a_cls.is_inf & b_cls.is_inf) | (a_cls.is_zero & b_cls.is_zero);
      default:         invalid_c = 1'b0;
    endcase
  end

  // Divide by zero only for a finite nonzero dividend.
  assign div_zero_c = (op == _DIVISION) & b_cls.is_zero &
                      ~a_cls.is_zero & ~a_cls.is_inf & ~a_cls.is_nan;

  // Priority resolution: at most one flag, with its special result.
  always_comb begin
    flags_c  = '0;
    result_c = '0;
    if (any_nan_c) begin
      flags_c[FLAG_NAN] = 1'b1;
      result_c          = _QNAN;
    end else if (invalid_c) begin
      flags_c[FLAG_INVALID] = 1'b1;
      result_c              = _QNAN;
    end else if (div_zero_c) begin
      flags_c[FLAG_DIV_ZERO] = 1'b1;
      result_c               = signed_inf(prod_sign_c);
    end else if (any_inf_c) begin
      flags_c[FLAG_INF] = 1'b1;
      case (op)
        _ADDITION,
        _SUBTRACTION: begin
          // A infinite passes through; B alone is negated for subtraction.
          if (a_cls.is_inf) begin
            result_c = signed_inf(a_cls.sign);
          end else begin
            result_c = signed_inf(b_cls.sign ^ (op == _SUBTRACTION));
          end
        end
        _MULTIPLICATION: result_c = signed_inf(prod_sign_c);
        _DIVISION: begin
          // Inf/Inf is already invalid, so exactly one side is infinite here.
          if (a_cls.is_inf) begin
            result_c = signed_inf(prod_sign_c);
          end else begin
            result_c = signed_zero(prod_sign_c);
          end
        end
        default: result_c = '0;
      endcase
    end
  end

  // Output registers; payload holds while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      exception      <= 1'b0;
      flags          <= '0;
      special_result <= '0;
      out_valid      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        exception      <= |flags_c;
        flags          <= flags_c;
        special_result <= result_c;
      end
    end
  end

endmodule

// File: tb/tb_fpu8_exception_unit.sv
// Self-checking bench for fpu8_exception_unit: a reference model checked
// every cycle, plus directed vectors with literal expected values.
module tb_fpu8_exception_unit;

  logic       clk;
  logic       rst;
  logic [1:0] op;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       in_valid;
  logic       exception;
  logic [3:0] flags;
  logic [7:0] special_result;
  logic       out_valid;

  int checks;
  int failures;
  bit checking;

  // Model state: what the registered outputs must hold.
  logic [3:0] m_flags;
  logic [7:0] m_result;
  logic       m_valid;

  fpu8_exception_unit dut (
    .clk            (clk),
    .rst            (rst),
    .op             (op),
    .in0            (in0),
    .in1            (in1),
    .in_valid       (in_valid),
    .exception      (exception),
    .flags          (flags),
    .special_result (special_result),
    .out_valid      (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {flags, result} from the exception rules.
  function automatic logic [11:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [3:0] ae, be;
    logic [2:0] am, bm;
    logic sa, sb, sbe, sp;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0] inf_p, inf_n;
    inf_p = 8'h78;
    inf_n = 8'hF8;
    ae = a[6:3]; am = a[2:0]; sa = a[7];
    be = b[6:3]; bm = b[2:0]; sb = b[7];
    a_nan  = (ae == 4'd15) && (am != 3'd0);
    b_nan  = (be == 4'd15) && (bm != 3'd0);
    a_inf  = (ae == 4'd15) && (am == 3'd0);
    b_inf  = (be == 4'd15) && (bm == 3'd0);
    a_zero = (ae == 4'd0) && (am == 3'd0);
    b_zero = (be == 4'd0) && (bm == 3'd0);
    sp  = sa ^ sb;
    sbe = sb ^ (o == 2'b01);  // subtraction adds a negated B
    if (a_nan || b_nan) return {4'b1000, 8'h7C};
    if (o <= 2'b01) begin
      if (a_inf && b_inf && (sa != sbe)) return {4'b0100, 8'h7C};
      if (a_inf) return {4'b0001, sa ? inf_n : inf_p};
      if (b_inf) return {4'b0001, sbe ? inf_n : inf_p};
      return 12'h000;
    end
    if (o == 2'b10) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) return {4'b0100, 8'h7C};
      if (a_inf || b_inf) return {4'b0001, sp ? inf_n : inf_p};
      return 12'h000;
    end
    if ((a_inf && b_inf) || (a_zero && b_zero)) return {4'b0100, 8'h7C};
    if (b_zero && !a_inf) return {4'b0010, sp ? inf_n : inf_p};
    if (a_inf) return {4'b0001, sp ? inf_n : inf_p};
    if (b_inf) return {4'b0001, sp ? 8'h80 : 8'h00};
    return 12'h000;
  endfunction

  // Model register update on the same edge as the DUT.
  always @(posedge clk) begin
    logic [11:0] r;
    r = model(op, in0, in1);
    if (rst) begin
      m_flags  <= 4'h0;
      m_result <= 8'h00;
      m_valid  <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_flags  <= r[11:8];
        m_result <= r[7:0];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checks++;
      if (flags !== m_flags || special_result !== m_result ||
          out_valid !== m_valid || exception !== (|m_flags)) begin
        failures++;
        $display("FAIL model_cycle t=%0t got flags=%b res=%h exc=%b ov=%b want flags=%b res=%h exc=%b ov=%b",
                 $time, flags, special_result, exception, out_valid,
                 m_flags, m_result, |m_flags, m_valid);
      end
    end
  end

  task automatic apply(input logic r, input logic v, input logic [1:0] o,
                       input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    op       = o;
    in0      = a;
    in1      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [3:0] ef,
                           input logic [7:0] er, input logic ev);
    checks++;
    if (flags !== ef || special_result !== er || exception !== (|ef) || out_valid !== ev) begin
      failures++;
      $display("FAIL %s got flags=%b res=%h exc=%b ov=%b want flags=%b res=%h exc=%b ov=%b",
               name, flags, special_result, exception, out_valid, ef, er, |ef, ev);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    checking = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    op       = 2'b00;
    in0      = 8'h00;
    in1      = 8'h00;
    @(posedge clk);
    #1;
    checking = 1'b1;
    check_lit("reset_state", 4'b0000, 8'h00, 1'b0);
    apply(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);

    apply(1'b0, 1'b1, 2'b00, 8'h78, 8'h00); check_lit("inf_add_zero", 4'b0001, 8'h78, 1'b1);
    apply(1'b0, 1'b1, 2'b01, 8'h78, 8'h00); check_lit("inf_sub_zero", 4'b0001, 8'h78, 1'b1);
    apply(1'b0, 1'b1, 2'b10, 8'h78, 8'h00); check_lit("inf_mul_zero", 4'b0100, 8'h7C, 1'b1);
    apply(1'b0, 1'b1, 2'b11, 8'h78, 8'h00); check_lit("inf_div_zero", 4'b0001, 8'h78, 1'b1);
    apply(1'b0, 1'b1, 2'b11, 8'h38, 8'h00); check_lit("one_div_zero", 4'b0010, 8'h78, 1'b1);
    apply(1'b0, 1'b1, 2'b11, 8'hB8, 8'h00); check_lit("mone_div_zero", 4'b0010, 8'hF8, 1'b1);
    apply(1'b0, 1'b1, 2'b11, 8'h00, 8'h00); check_lit("zero_div_zero", 4'b0100, 8'h7C, 1'b1);
    apply(1'b0, 1'b1, 2'b00, 8'h78, 8'hF8); check_lit("pinf_add_ninf", 4'b0100, 8'h7C, 1'b1);
    apply(1'b0, 1'b1, 2'b01, 8'h78, 8'h78); check_lit("pinf_sub_pinf", 4'b0100, 8'h7C, 1'b1);
    apply(1'b0, 1'b1, 2'b01, 8'h38, 8'h78); check_lit("one_sub_pinf", 4'b0001, 8'hF8, 1'b1);
    apply(1'b0, 1'b1, 2'b11, 8'h38, 8'hF8); check_lit("one_div_ninf", 4'b0001, 8'h80, 1'b1);
    apply(1'b0, 1'b1, 2'b10, 8'h00, 8'hF8); check_lit("zero_mul_ninf", 4'b0100, 8'h7C, 1'b1);
    apply(1'b0, 1'b1, 2'b10, 8'hF8, 8'h38); check_lit("ninf_mul_one", 4'b0001, 8'hF8, 1'b1);
    apply(1'b0, 1'b1, 2'b11, 8'hF8, 8'hB8); check_lit("ninf_div_mone", 4'b0001, 8'h78, 1'b1);
    apply(1'b0, 1'b1, 2'b00, 8'h38, 8'hFF); check_lit("nan_in_b", 4'b1000, 8'h7C, 1'b1);

    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b1, 2'(k), 8'h79, 8'h00);
      check_lit("nan_priority", 4'b1000, 8'h7C, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b1, 2'(k), 8'h38, 8'h40);
      check_lit("normal_ops", 4'b0000, 8'h00, 1'b1);
    end

    // Subnormal dividend is finite nonzero.
    apply(1'b0, 1'b1, 2'b11, 8'h01, 8'h00); check_lit("subnorm_div_zero", 4'b0010, 8'h78, 1'b1);
    // Idle cycle holds the payload and drops out_valid.
    apply(1'b0, 1'b0, 2'b10, 8'h78, 8'h00); check_lit("idle_hold", 4'b0010, 8'h78, 1'b0);
    // Reset wins over a valid exceptional input.
    apply(1'b1, 1'b1, 2'b10, 8'h78, 8'h00); check_lit("reset_wins", 4'b0000, 8'h00, 1'b0);
    apply(1'b0, 1'b1, 2'b10, 8'h78, 8'h00); check_lit("after_reset", 4'b0100, 8'h7C, 1'b1);

    // Randomised traffic biased toward special encodings, checked by the model.
    for (int k = 0; k < 300; k++) begin
      logic [7:0] a, b;
      logic [7:0] pick [8];
      pick = '{8'h00, 8'h80, 8'h78, 8'hF8, 8'h7C, 8'hFB, 8'h01, 8'h38};
      a = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : 8'($urandom);
      b = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : 8'($urandom);
      apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), a, b);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu8_exception_unit.md
Name: fpu8_exception_unit

Overview:
- Special-case and exception detector for the 8-bit FPU.
- Sits beside the add/sub/mul/div datapaths and classifies both operands.
- Flags any exceptional combination of opcode and operands, and supplies the IEEE-style special result that the FPU output mux selects instead of the datapath result.
- Registered, single-cycle latency.

Parameters:
- EXP_W, 4, exponent field width (format is 1 sign, 4 exponent, 3 mantissa; bias 7).
- MAN_W, 3, mantissa field width; total width is 1+EXP_W+MAN_W = 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  2  operation: ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11.
- in0  in  8  operand A (minuend, dividend).
- in1  in  8  operand B (subtrahend, divisor).
- in_valid  in  1  operands and op valid this cycle.
- exception  out  1  any flag set (OR of the four flag bits).
- flags  out  4  {nan_operand, invalid, div_by_zero, inf_operand}.
- special_result  out  8  result the FPU must output when exception=1; 8'h00 otherwise.
- out_valid  out  1  in_valid delayed by one cycle.

Behaviour:
- Classification, combinational per operand:
  - NaN: exp=4'hF, man≠0.
  - Inf: exp=4'hF, man=0.
  - Zero: exp=0, man=0.
  - Subnormals are finite nonzero.
- Constants:
  - +INF=8'h78, -INF=8'hF8.
  - Canonical NaN=8'h7C, always positive sign.
  - +0=8'h00, -0=8'h80.
- Priority of rules, highest first:
  1. Any NaN operand: nan_operand=1, result NaN.
  2. Invalid combinations: invalid=1, result NaN.
     - ADD: Inf + Inf of opposite signs.
     - SUB: Inf − Inf of same sign.
     - MUL: Inf × 0, either order.
     - DIV: Inf/Inf, 0/0.
  3. DIV with B=0 and A finite nonzero: div_by_zero=1, result Inf with sign sA^sB.
  4. Any Inf operand, remaining cases: inf_operand=1.
     - ADD/SUB: result is the Inf operand; for SUB with only B infinite, B's sign is inverted.
     - MUL: Inf with sign sA^sB.
     - DIV: Inf/finite gives Inf with sign sA^sB; finite/Inf gives zero with sign sA^sB.
- Within a rule, lower-priority flags are not set. Exactly one flag bit or none is set.
- exception = |flags. No flags: special_result=8'h00.
- All outputs are registered on the rising clk edge when in_valid=1.
- When in_valid=0, the output registers hold their value except out_valid, which goes 0.
- Latency is 1 cycle; no backpressure; a new operation is accepted every cycle.
- Reset: exception=0, flags=0, special_result=8'h00, out_valid=0.
- Reset wins over a simultaneous in_valid.
- Normal finite operands never raise flags. Overflow, underflow and inexact belong to the arithmetic units.

Decomposition:
- Shared package fpu8_pkg:
  - opcode localparams _ADDITION, _SUBTRACTION, _MULTIPLICATION, _DIVISION.
  - _PLUS_INF, _MINUS_INF, _QNAN, _POS_ZERO, _NEG_ZERO.
  - field widths and flag bit indices.
- Sub-module fpu8_classify: one operand in, outputs is_nan, is_inf, is_zero, sign. Instantiated twice.
- Rule logic and output registers live in the top module.

Test Plan:
- in0=8'h78, in1=8'h00, op=ADD then SUB, in_valid=1 → next cycle: exception=1, inf_operand=1, special_result=8'h78.
  - Same operands, MUL → invalid=1, special_result=8'h7C.
  - Same operands, DIV → inf_operand=1, special_result=8'h78.
- in0=8'h38 (1.0), in1=8'h00, DIV → div_by_zero=1, special_result=8'h78.
  - in0=8'hB8 instead → special_result=8'hF8.
  - in0=8'h00, in1=8'h00, DIV → invalid=1, special_result=8'h7C.
- Inf/NaN combinations:
  - 8'h78 ADD 8'hF8 → invalid.
  - 8'h78 SUB 8'h78 → invalid.
  - 8'h38 SUB 8'h78 → inf_operand, special_result=8'hF8.
  - 8'h38 DIV 8'hF8 → special_result=8'h80.
- NaN priority: in0=8'h79, in1=8'h00, every op → nan_operand only, special_result=8'h7C.
- Normal operands: 8'h38 with 8'h40, all ops → exception=0, flags=0, special_result=8'h00.
- Reset and valid:
  - Assert rst with in_valid=1 and exceptional operands → outputs all zero next cycle.
  - in_valid=0 → out_valid=0, other outputs hold.
